// File: rtl/regs_pkg.sv
// Shared types for the 16x16 register file write path: geometry constants and
// the writeback request carried from the lanes through the FIFO.
package regs_pkg;

  localparam int REG_AW = 4;
  localparam int REG_DW = 16;
  localparam int NREGS  = 16;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [REG_DW-1:0] data;
  } wb_req_t;

  function automatic logic [NREGS-1:0] reg_onehot(input logic [REG_AW-1:0] a);
    return NREGS'(1) << a;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular FIFO of writeback requests; also exposes per-slot valid bits and
// addresses so the owner can build a pending-write (busy) vector.
module wb_fifo
  import regs_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  wb_req_t                       push_req,
  input  logic                          pop,
  output wb_req_t                       head,
  output logic                          full,
  output logic                          empty,
  output logic [AW:0]                   count,
  output logic [DEPTH-1:0]              entry_valid,
  output logic [DEPTH-1:0][REG_AW-1:0]  entry_addr
);

  wb_req_t          mem_q [DEPTH];
  wb_req_t          mem_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];
  assign entry_valid = valid_q;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) entry_addr[i] = mem_q[i].addr;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = push && !full;
    do_pop   = pop && !empty;
    if (do_push) begin
      mem_d[wr_ptr_q]   = push_req;
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/regs_wb_arbiter.sv
// Register-file write front end: round-robin lane arbiter, shared FIFO, and a
// registered single write port. Optional counters under REGS_WB_STATS_EN.
module regs_wb_arbiter
  import regs_pkg::*;
#(
  parameter int NLANES  = 2,
  parameter int DEPTH   = 4,
  parameter int DROP_R0 = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NLANES-1:0]        lane_valid,
  output logic [NLANES-1:0]        lane_ready,
  input  logic [4*NLANES-1:0]      lane_addr,
  input  logic [16*NLANES-1:0]     lane_data,
  input  logic                     wb_hold,
  output logic                     wen,
  output logic [REG_AW-1:0]        waddr,
  output logic [REG_DW-1:0]        wdata,
  output logic [NREGS-1:0]         busy,
  output logic                     fifo_full,
  output logic                     fifo_empty
`ifdef REGS_WB_STATS_EN
  ,
  output logic [15:0]              stall_cnt,
  output logic [15:0]              drop_cnt
`endif
);

  localparam int RRW = (NLANES > 1) ? $clog2(NLANES) : 1;
  localparam int AW  = $clog2(DEPTH);

  // Handshake: lane i transfers when lane_valid[i] && lane_ready[i] in the same
  // cycle; lane_ready never depends on anything registered in that lane.
  logic [RRW-1:0]   rr_q, rr_d;
  logic [RRW-1:0]   grant_idx;
  logic             grant_found;
  logic [REG_AW-1:0] grant_addr;
  logic [REG_DW-1:0] grant_data;
  logic             is_r0, handshake, push, drop, pop;

  wb_req_t                     head;
  logic                        f_full, f_empty;
  logic [AW:0]                 f_count;
  logic [DEPTH-1:0]            f_valid;
  logic [DEPTH-1:0][REG_AW-1:0] f_addr;

  logic              wen_q, wen_d;
  logic [REG_AW-1:0] waddr_q, waddr_d;
  logic [REG_DW-1:0] wdata_q, wdata_d;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < NLANES; i++) begin
      int idx;
      idx = (int'(rr_q) + i) % NLANES;
      if (!grant_found && lane_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = RRW'(idx);
      end
    end
  end

  assign grant_addr = lane_addr[int'(grant_idx)*4 +: 4];
  assign grant_data = lane_data[int'(grant_idx)*16 +: 16];
  assign is_r0      = (DROP_R0 != 0) && (grant_addr == '0);

  // A dropped r0 write needs no FIFO slot, so it is accepted even when full.
  assign handshake  = grant_found && !rst && (!f_full || is_r0);
  assign push       = handshake && !is_r0;
  assign drop       = handshake && is_r0;
  assign lane_ready = handshake ? (NLANES'(1) << grant_idx) : '0;
  assign pop        = !f_empty && !wb_hold;

  always_comb begin
    rr_d = rr_q;
    if (handshake) rr_d = (grant_idx == RRW'(NLANES - 1)) ? '0 : grant_idx + 1'b1;
  end

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .push_req    ('{addr: grant_addr, data: grant_data}),
    .pop         (pop),
    .head        (head),
    .full        (f_full),
    .empty       (f_empty),
    .count       (f_count),
    .entry_valid (f_valid),
    .entry_addr  (f_addr)
  );

  always_comb begin
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (pop) begin
      wen_d   = 1'b1;
      waddr_d = head.addr;
      wdata_d = head.data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q    <= '0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      rr_q    <= rr_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign wen        = wen_q;
  assign waddr      = waddr_q;
  assign wdata      = wdata_q;
  assign fifo_full  = f_full;
  assign fifo_empty = (f_count == '0);

  // A register stays busy while queued or while its write sits in the output stage.
  always_comb begin
    busy = '0;
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (f_valid[i]) busy = busy | reg_onehot(f_addr[i]);
      end
      if (wen_q) busy = busy | reg_onehot(waddr_q);
    end
  end

`ifdef REGS_WB_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    if ((|lane_valid) && !handshake && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
    if (drop && (drop_cnt_q != 16'hFFFF))
      drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign drop_cnt  = drop_cnt_q;
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_regs_wb_arbiter.sv
// Directed bench for regs_wb_arbiter: queue-based reference model checked every
// cycle, plus hand-computed expectations for each scenario.
module tb_regs_wb_arbiter;
  import regs_pkg::*;

  localparam int NL    = 2;
  localparam int DEPTH = 4;

  logic              clk;
  logic              rst;
  logic [NL-1:0]     lane_valid;
  logic [NL-1:0]     lane_ready;
  logic [4*NL-1:0]   lane_addr;
  logic [16*NL-1:0]  lane_data;
  logic              wb_hold;
  logic              wen;
  logic [3:0]        waddr;
  logic [15:0]       wdata;
  logic [15:0]       busy;
  logic              fifo_full;
  logic              fifo_empty;
`ifdef REGS_WB_STATS_EN
  logic [15:0]       stall_cnt;
  logic [15:0]       drop_cnt;
`endif

  regs_wb_arbiter #(.NLANES(NL), .DEPTH(DEPTH), .DROP_R0(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .lane_valid (lane_valid),
    .lane_ready (lane_ready),
    .lane_addr  (lane_addr),
    .lane_data  (lane_data),
    .wb_hold    (wb_hold),
    .wen        (wen),
    .waddr      (waddr),
    .wdata      (wdata),
    .busy       (busy),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty)
`ifdef REGS_WB_STATS_EN
    ,
    .stall_cnt  (stall_cnt),
    .drop_cnt   (drop_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Pending writes in acceptance order, each {addr, data}.
  logic [19:0] exp_q[$];
  int          m_rr    = 0;
  logic        m_wen   = 1'b0;
  logic [3:0]  m_waddr = '0;
  logic [15:0] m_wdata = '0;

  always @(negedge clk) begin : model
    logic [NL-1:0] er;
    logic [15:0]   eb;
    logic [3:0]    ga;
    logic [19:0]   ent;
    int            g;
    int            k;
    bit            hs;
    er = '0;
    eb = '0;
    ga = '0;
    g  = -1;
    hs = 1'b0;
    if (!rst) begin
      for (int i = 0; i < NL; i++) begin
        k = (m_rr + i) % NL;
        if (g < 0 && lane_valid[k]) g = k;
      end
      if (g >= 0) begin
        ga = lane_addr[g*4 +: 4];
        if (exp_q.size() < DEPTH || ga == 4'd0) begin
          er[g] = 1'b1;
          hs    = 1'b1;
        end
      end
      foreach (exp_q[j]) eb[exp_q[j][19:16]] = 1'b1;
      if (m_wen) eb[m_waddr] = 1'b1;
    end
    check("model_lane_ready", lane_ready, er);
    check("model_wen", wen, m_wen);
    check("model_waddr", waddr, m_waddr);
    check("model_wdata", wdata, m_wdata);
    check("model_busy", busy, eb);
    check("model_full", fifo_full, exp_q.size() == DEPTH);
    check("model_empty", fifo_empty, exp_q.size() == 0);
    if (rst) begin
      exp_q.delete();
      m_rr    = 0;
      m_wen   = 1'b0;
      m_waddr = '0;
      m_wdata = '0;
    end else begin
      if (exp_q.size() > 0 && !wb_hold) begin
        ent     = exp_q.pop_front();
        m_wen   = 1'b1;
        m_waddr = ent[19:16];
        m_wdata = ent[15:0];
      end else begin
        m_wen = 1'b0;
      end
      if (hs) begin
        m_rr = (g + 1) % NL;
        if (ga != 4'd0) exp_q.push_back({ga, lane_data[g*16 +: 16]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input logic v, input logic [3:0] a, input logic [15:0] d);
    lane_valid[i]       = v;
    lane_addr[i*4 +: 4]  = a;
    lane_data[i*16 +: 16] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    rst        = 1'b1;
    lane_valid = '0;
    lane_addr  = '0;
    lane_data  = '0;
    wb_hold    = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("reset_wen", wen, 1'b0);
    check("reset_waddr", waddr, 4'd0);
    check("reset_wdata", wdata, 16'd0);
    check("reset_busy", busy, 16'd0);
    check("reset_empty", fifo_empty, 1'b1);

    // Single write: ready c1, busy c2..c3, wen c3, clear c4.
    tick();
    set_lane(0, 1'b1, 4'd5, 16'h1234);
    @(negedge clk);
    check("t1_ready", lane_ready, 2'b01);
    tick();
    set_lane(0, 1'b0, 4'd0, 16'h0);
    @(negedge clk);
    check("t1_busy_c2", busy[5], 1'b1);
    check("t1_wen_c2", wen, 1'b0);
    tick();
    @(negedge clk);
    check("t1_wen_c3", wen, 1'b1);
    check("t1_waddr_c3", waddr, 4'd5);
    check("t1_wdata_c3", wdata, 16'h1234);
    check("t1_busy_c3", busy[5], 1'b1);
    tick();
    @(negedge clk);
    check("t1_busy_c4", busy, 16'd0);
    check("t1_wen_c4", wen, 1'b0);

    // Round-robin: both lanes valid for 4 cycles -> grants 0,1,0,1.
    do_reset();
    for (int c = 0; c < 6; c++) begin
      set_lane(0, c < 4, 4'd1, 16'h0100 + 16'(c));
      set_lane(1, c < 4, 4'd2, 16'h0200 + 16'(c));
      @(negedge clk);
      if (c < 4) check("t2_grant", lane_ready, (c % 2 == 1) ? 2'b10 : 2'b01);
      if (c >= 2) begin
        check("t2_wen", wen, 1'b1);
        check("t2_waddr", waddr, ((c - 2) % 2 == 1) ? 4'd2 : 4'd1);
      end
      tick();
    end

    // Full under hold, then release.
    do_reset();
    wb_hold = 1'b1;
    for (int c = 0; c < 5; c++) begin
      set_lane(0, 1'b1, 4'(c + 1), 16'h0A00 + 16'(c));
      @(negedge clk);
      check("t3_fill_ready", lane_ready, (c < 4) ? 2'b01 : 2'b00);
      if (c < 4) tick();
    end
    check("t3_full", fifo_full, 1'b1);
    tick();
    wb_hold = 1'b0;
    @(negedge clk);
    check("t3_still_full_ready", lane_ready, 2'b00);
    tick();
    @(negedge clk);
    check("t3_fifth_ready", lane_ready, 2'b01);
    check("t3_wen0", wen, 1'b1);
    check("t3_waddr0", waddr, 4'd1);
    check("t3_wdata0", wdata, 16'h0A00);
    tick();
    set_lane(0, 1'b0, 4'd0, 16'h0);
    for (int j = 1; j < 5; j++) begin
      @(negedge clk);
      check("t3_wen", wen, 1'b1);
      check("t3_waddr", waddr, 4'(j + 1));
      check("t3_wdata", wdata, 16'h0A00 + 16'(j));
      tick();
    end
    @(negedge clk);
    check("t3_wen_done", wen, 1'b0);

    // r0 drop on lane 1.
    do_reset();
    set_lane(1, 1'b1, 4'd0, 16'hFFFF);
    @(negedge clk);
    check("t4_ready", lane_ready, 2'b10);
    tick();
    set_lane(1, 1'b0, 4'd0, 16'h0);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check("t4_no_wen", wen, 1'b0);
      check("t4_busy", busy, 16'd0);
      check("t4_empty", fifo_empty, 1'b1);
      tick();
    end
`ifdef REGS_WB_STATS_EN
    check("t4_drop_cnt", drop_cnt, 16'd1);
`endif

    // Reset with three entries queued under hold.
    do_reset();
    wb_hold = 1'b1;
    for (int c = 0; c < 3; c++) begin
      set_lane(0, 1'b1, 4'(9 + c), 16'(c + 1));
      tick();
    end
    set_lane(0, 1'b0, 4'd0, 16'h0);
    @(negedge clk);
    check("t5_busy_queued", busy, 16'h0E00);
    rst = 1'b1;
    set_lane(1, 1'b1, 4'd4, 16'h0055);
    @(negedge clk);
    check("t5_ready_in_rst", lane_ready, 2'b00);
    tick();
    rst = 1'b0;
    set_lane(1, 1'b0, 4'd0, 16'h0);
    @(negedge clk);
    check("t5_empty", fifo_empty, 1'b1);
    check("t5_busy", busy, 16'd0);
    check("t5_wen", wen, 1'b0);
    wb_hold = 1'b0;
    for (int j = 0; j < 3; j++) begin
      tick();
      @(negedge clk);
      check("t5_no_stale", wen, 1'b0);
    end

    // Same-register ordering.
    do_reset();
    set_lane(0, 1'b1, 4'd7, 16'd1);
    tick();
    set_lane(0, 1'b1, 4'd7, 16'd2);
    @(negedge clk);
    check("t6_ready2", lane_ready, 2'b01);
    check("t6_busy_c1", busy[7], 1'b1);
    tick();
    set_lane(0, 1'b0, 4'd0, 16'h0);
    @(negedge clk);
    check("t6_wen1", wen, 1'b1);
    check("t6_data1", wdata, 16'd1);
    check("t6_busy_c2", busy[7], 1'b1);
    tick();
    @(negedge clk);
    check("t6_wen2", wen, 1'b1);
    check("t6_data2", wdata, 16'd2);
    check("t6_busy_c3", busy[7], 1'b1);
    tick();
    @(negedge clk);
    check("t6_busy_c4", busy[7], 1'b0);

    tick();
    tick();
    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
